// File: rtl/riscv_loader_pkg.sv
// Shared state encoding and header field layout for riscv_instr_loader.
// The CHECK state only exists when LOADER_CHECKSUM_EN is defined.
package riscv_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2
`ifdef LOADER_CHECKSUM_EN
    , ST_CHECK = 2'd3
`endif
  } loader_state_e;

  localparam int HDR_MARK_BIT = 31;
  localparam int HDR_CNT_MSB  = 30;
  localparam int HDR_CNT_LSB  = 16;
  localparam int HDR_ADDR_MSB = 15;

  function automatic logic is_header(input logic [31:0] word);
    return word[HDR_MARK_BIT];
  endfunction

  function automatic logic [HDR_CNT_MSB-HDR_CNT_LSB:0] hdr_count(input logic [31:0] word);
    return word[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

  function automatic logic [HDR_ADDR_MSB:0] hdr_addr(input logic [31:0] word);
    return word[HDR_ADDR_MSB:0];
  endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// Write pointer (wraps modulo 2^ADDR_BITS) plus remaining / words-loaded
// counters for the instruction loader; header latch has priority over step.
module loader_addr_gen #(
  parameter int ADDR_BITS  = 10,
  parameter int COUNT_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [COUNT_BITS-1:0] count,
  input  logic                  step,
  output logic [ADDR_BITS-1:0]  addr_ptr,
  output logic [COUNT_BITS-1:0] remaining,
  output logic [COUNT_BITS-1:0] words_loaded
);

  logic [ADDR_BITS-1:0]  addr_ptr_r;
  logic [COUNT_BITS-1:0] remaining_r;
  logic [COUNT_BITS-1:0] words_loaded_r;

  // pointer and counters: latch on header, advance once per data word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_ptr_r     <= {ADDR_BITS{1'b0}};
      remaining_r    <= {COUNT_BITS{1'b0}};
      words_loaded_r <= {COUNT_BITS{1'b0}};
    end else if (load) begin
      addr_ptr_r     <= start_addr;
      remaining_r    <= count;
      words_loaded_r <= {COUNT_BITS{1'b0}};
    end else if (step) begin
      addr_ptr_r     <= addr_ptr_r + ADDR_BITS'(1);
      remaining_r    <= remaining_r - COUNT_BITS'(1);
      words_loaded_r <= words_loaded_r + COUNT_BITS'(1);
    end else begin
      addr_ptr_r     <= addr_ptr_r;
      remaining_r    <= remaining_r;
      words_loaded_r <= words_loaded_r;
    end
  end

  assign addr_ptr     = addr_ptr_r;
  assign remaining    = remaining_r;
  assign words_loaded = words_loaded_r;

endmodule

// File: rtl/riscv_instr_loader.sv
// Loads a header-described program image into the instruction BRAM and holds
// the core in reset meanwhile. Optional trailing XOR check: LOADER_CHECKSUM_EN.
module riscv_instr_loader
  import riscv_loader_pkg::*;
#(
  parameter int ADDR_BITS  = 10,
  parameter int COUNT_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           instr_packet,
  input  logic                  instr_wr_en,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_err,
  output logic [COUNT_BITS-1:0] words_loaded
);

  loader_state_e         state_r;
  logic                  mem_we_r;
  logic [ADDR_BITS-1:0]  mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic                  cpu_reset_r;
  logic                  load_done_r;
  logic                  done_pend_r;

  logic                  hdr_s;
  logic                  data_s;
  logic [COUNT_BITS-1:0] hdr_cnt_s;
  logic [ADDR_BITS-1:0]  hdr_addr_s;
  logic [ADDR_BITS-1:0]  addr_ptr_s;
  logic [COUNT_BITS-1:0] remaining_s;
  logic [COUNT_BITS-1:0] words_loaded_s;

  assign hdr_cnt_s  = COUNT_BITS'(hdr_count(instr_packet));
  assign hdr_addr_s = ADDR_BITS'(hdr_addr(instr_packet));
  assign hdr_s      = instr_wr_en && is_header(instr_packet) &&
                      (state_r == ST_IDLE || state_r == ST_DONE);
  assign data_s     = instr_wr_en && (state_r == ST_LOAD);

  loader_addr_gen #(
    .ADDR_BITS  (ADDR_BITS),
    .COUNT_BITS (COUNT_BITS)
  ) u_addr_gen (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (hdr_s),
    .start_addr   (hdr_addr_s),
    .count        (hdr_cnt_s),
    .step         (data_s),
    .addr_ptr     (addr_ptr_s),
    .remaining    (remaining_s),
    .words_loaded (words_loaded_s)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_r;
  logic        load_err_r;

  // running XOR of the data words of the current image
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum_r <= 32'd0;
    end else if (hdr_s) begin
      csum_r <= 32'd0;
    end else if (data_s) begin
      csum_r <= csum_r ^ instr_packet;
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  // loader FSM with registered BRAM write port and core-reset control
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_BITS{1'b0}};
      mem_wdata_r <= 32'd0;
      cpu_reset_r <= 1'b1;
      load_done_r <= 1'b0;
      done_pend_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      load_err_r  <= 1'b0;
`endif
    end else begin
      mem_we_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (hdr_s) begin
            cpu_reset_r <= 1'b1;
            load_done_r <= 1'b0;
            done_pend_r <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            load_err_r  <= 1'b0;
`endif
            if (hdr_cnt_s != {COUNT_BITS{1'b0}}) begin
              state_r <= ST_LOAD;
            end else begin
`ifdef LOADER_CHECKSUM_EN
              state_r <= ST_CHECK;
`else
              // empty image: nothing to write, release the core right away
              state_r     <= ST_DONE;
              load_done_r <= 1'b1;
              cpu_reset_r <= 1'b0;
`endif
            end
          end else if (done_pend_r) begin
            // release one cycle after the final write has reached the BRAM
            load_done_r <= 1'b1;
            cpu_reset_r <= 1'b0;
            done_pend_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (data_s) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= addr_ptr_s;
            mem_wdata_r <= instr_packet;
            if (remaining_s == COUNT_BITS'(1)) begin
`ifdef LOADER_CHECKSUM_EN
              state_r <= ST_CHECK;
`else
              state_r     <= ST_DONE;
              done_pend_r <= 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (instr_wr_en) begin
            state_r <= ST_DONE;
            if (instr_packet == csum_r) begin
              load_done_r <= 1'b1;
              cpu_reset_r <= 1'b0;
            end else begin
              load_err_r <= 1'b1;
            end
          end
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign cpu_reset    = cpu_reset_r;
  assign load_done    = load_done_r;
  assign words_loaded = words_loaded_s;
`ifdef LOADER_CHECKSUM_EN
  assign load_err     = load_err_r;
`else
  assign load_err     = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_instr_loader.sv
// Directed bench for riscv_instr_loader: reset, single/wrap/zero-count loads,
// ignored non-headers, reload, mid-load reset and gapped strobes.
module tb_riscv_instr_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_packet;
  logic        instr_wr_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [14:0] words_loaded;

  int n_tests  = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int base;

  logic [31:0] bram [0:1023];
  logic [31:0] vec  [0:15];

  always #5 clk = ~clk;

  riscv_instr_loader #(
    .ADDR_BITS  (10),
    .COUNT_BITS (15)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr_packet (instr_packet),
    .instr_wr_en  (instr_wr_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  // BRAM image as the write port would store it
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
      wr_count       <= wr_count + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_write(input string tag, input int i, input logic [9:0] start);
    logic [9:0] a;
    a = start + 10'(i);
    check_eq({tag, " mem_we"},    32'(mem_we),   32'd1);
    check_eq({tag, " mem_addr"},  32'(mem_addr), 32'(a));
    check_eq({tag, " mem_wdata"}, mem_wdata,     vec[i]);
  endtask

  task automatic run_load(input string tag, input int n, input logic [9:0] start, input int gap_max);
    int b;
    logic [31:0] csum;
    logic [9:0]  a;
    b = wr_count;
    csum = 32'd0;
    @(negedge clk);
    instr_packet = {1'b1, 15'(n), 6'd0, start};
    instr_wr_en  = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_eq({tag, " hdr cpu_reset"}, 32'(cpu_reset), 32'd1);
        check_eq({tag, " hdr load_done"}, 32'(load_done), 32'd0);
        check_eq({tag, " hdr mem_we"},    32'(mem_we),    32'd0);
      end else begin
        check_write(tag, i - 1, start);
      end
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
          instr_wr_en = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      instr_packet = vec[i];
      instr_wr_en  = 1'b1;
      csum = csum ^ vec[i];
    end
    @(negedge clk);
    check_write(tag, n - 1, start);
    check_eq({tag, " busy cpu_reset"}, 32'(cpu_reset), 32'd1);
`ifdef LOADER_CHECKSUM_EN
    instr_packet = csum;
    @(negedge clk);
`endif
    instr_wr_en = 1'b0;
    @(negedge clk);
    check_eq({tag, " load_done"},    32'(load_done),    32'd1);
    check_eq({tag, " cpu_reset"},    32'(cpu_reset),    32'd0);
    check_eq({tag, " load_err"},     32'(load_err),     32'd0);
    check_eq({tag, " idle mem_we"},  32'(mem_we),       32'd0);
    check_eq({tag, " words_loaded"}, 32'(words_loaded), 32'(n));
    check_eq({tag, " write count"},  32'(wr_count - b), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = start + 10'(i);
      check_eq({tag, " bram"}, bram[a], vec[i]);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    instr_packet = 32'd0;
    instr_wr_en  = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst mem_we",       32'(mem_we),       32'd0);
    check_eq("rst mem_addr",     32'(mem_addr),     32'd0);
    check_eq("rst mem_wdata",    mem_wdata,         32'd0);
    check_eq("rst cpu_reset",    32'(cpu_reset),    32'd1);
    check_eq("rst load_done",    32'(load_done),    32'd0);
    check_eq("rst load_err",     32'(load_err),     32'd0);
    check_eq("rst words_loaded", 32'(words_loaded), 32'd0);
    reset_n = 1'b1;

    // non-header word in IDLE is ignored
    @(negedge clk);
    instr_packet = 32'h1234_5678;
    instr_wr_en  = 1'b1;
    @(negedge clk);
    instr_wr_en = 1'b0;
    check_eq("idle nonhdr mem_we",    32'(mem_we),    32'd0);
    check_eq("idle nonhdr cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("idle nonhdr load_done", 32'(load_done), 32'd0);

    // zero-count header completes without any write
    base = wr_count;
    instr_packet = 32'h8000_0005;
    instr_wr_en  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    instr_packet = 32'd0;
`endif
    @(negedge clk);
    instr_wr_en = 1'b0;
    check_eq("zero load_done",    32'(load_done),    32'd1);
    check_eq("zero cpu_reset",    32'(cpu_reset),    32'd0);
    check_eq("zero mem_we",       32'(mem_we),       32'd0);
    check_eq("zero words_loaded", 32'(words_loaded), 32'd0);
    @(negedge clk);
    check_eq("zero write count",  32'(wr_count - base), 32'd0);

    for (int i = 0; i < 16; i++) vec[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
    vec[0] = 32'hAAAA_0001; vec[1] = 32'hBBBB_0002;
    vec[2] = 32'hCCCC_0003; vec[3] = 32'hDDDD_0004;
    run_load("single", 4, 10'h010, 0);

    // non-header word in DONE is ignored
    @(negedge clk);
    instr_packet = 32'h1234_5678;
    instr_wr_en  = 1'b1;
    @(negedge clk);
    instr_wr_en = 1'b0;
    check_eq("done nonhdr mem_we",       32'(mem_we),       32'd0);
    check_eq("done nonhdr load_done",    32'(load_done),    32'd1);
    check_eq("done nonhdr words_loaded", 32'(words_loaded), 32'd4);

    vec[0] = 32'h0000_0013; vec[1] = 32'h0010_0093; vec[2] = 32'h0000_006F;
    run_load("wrap", 3, 10'h3FE, 0);

    // reset mid-load after two of four words
    for (int i = 0; i < 4; i++) vec[i] = 32'h5A00_0000 + 32'(i);
    base = wr_count;
    @(negedge clk);
    instr_packet = {1'b1, 15'd4, 6'd0, 10'h100};
    instr_wr_en  = 1'b1;
    @(negedge clk);
    instr_packet = vec[0];
    @(negedge clk);
    instr_packet = vec[1];
    @(negedge clk);
    instr_wr_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("mid rst cpu_reset",    32'(cpu_reset),    32'd1);
    check_eq("mid rst load_done",    32'(load_done),    32'd0);
    check_eq("mid rst words_loaded", 32'(words_loaded), 32'd0);
    check_eq("mid rst mem_addr",     32'(mem_addr),     32'd0);
    check_eq("mid rst write count",  32'(wr_count - base), 32'd2);
    check_eq("mid rst bram0",        bram[10'h100],     vec[0]);
    check_eq("mid rst bram1",        bram[10'h101],     vec[1]);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 4; i++) vec[i] = 32'h6B00_0010 + 32'(i);
    run_load("after rst", 4, 10'h100, 0);

    for (int i = 0; i < 8; i++) vec[i] = 32'h7C00_1000 ^ 32'(i * 32'h0011_0003);
    run_load("gapped", 8, 10'h200, 20);

`ifdef LOADER_CHECKSUM_EN
    vec[0] = 32'd1; vec[1] = 32'd2; vec[2] = 32'd4;
    run_load("csum ok", 3, 10'h300, 0);
    base = wr_count;
    @(negedge clk);
    instr_packet = {1'b1, 15'd3, 6'd0, 10'h300};
    instr_wr_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_packet = vec[i];
    end
    @(negedge clk);
    instr_packet = 32'd6;
    @(negedge clk);
    instr_wr_en = 1'b0;
    @(negedge clk);
    check_eq("csum bad load_err",    32'(load_err),  32'd1);
    check_eq("csum bad cpu_reset",   32'(cpu_reset), 32'd1);
    check_eq("csum bad load_done",   32'(load_done), 32'd0);
    check_eq("csum bad write count", 32'(wr_count - base), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_instr_loader.md
Name: riscv_instr_loader

Overview:
- Downstream consumer of the leaf interface's RISC-V instruction word stream (`instr_packet` / `instr_wr_en`).
- Parses a header word, then writes the following N instruction words into the RISC-V instruction BRAM at consecutive word addresses.
- Holds the RISC-V core in reset while a program image is loading, and releases it once the load completes.
- Sits between the packet-extract stage and the riscv_bram instruction memory write port.

Parameters:
- ADDR_BITS, 10, instruction BRAM word-address width (depth 2^ADDR_BITS); legal range 1..16.
- COUNT_BITS, 15, width of the header word-count field; fixed at 15 by the header format.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- instr_packet, input, 32, instruction/header word from the extract stage.
- instr_wr_en, input, 1, one-cycle strobe; `instr_packet` is valid when high.
- mem_we, output, 1, BRAM write enable.
- mem_addr, output, ADDR_BITS, BRAM word address.
- mem_wdata, output, 32, BRAM write data.
- cpu_reset, output, 1, active-high reset to the RISC-V core.
- load_done, output, 1, level; high after a successful load.
- load_err, output, 1, level; high after a failed load (checksum build only).
- words_loaded, output, COUNT_BITS, number of data words written in the current or last load.

Behaviour:
- Reset values (async, reset_n=0):
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, load_done=0, load_err=0, words_loaded=0.
  - State=IDLE.
- Header word format:
  - [31]=1 start marker.
  - [30:16]=word count N.
  - [15:0]=start word address; only the low ADDR_BITS bits are used.
- States: IDLE, LOAD, DONE (plus CHECK when LOADER_CHECKSUM_EN is defined).
- IDLE:
  - Strobe with bit31=1 latches the header: addr_ptr=start, remaining=N, words_loaded=0, cpu_reset stays 1.
  - Next state is LOAD if N>0, otherwise DONE.
  - Strobe with bit31=0 is ignored.
- LOAD:
  - Every strobe is data, regardless of bit31.
  - Registered write the cycle after the strobe: mem_we=1, mem_addr=addr_ptr, mem_wdata=instr_packet. Latency is exactly 1 cycle; mem_we is high for exactly 1 cycle per strobe.
  - After each write: addr_ptr increments modulo 2^ADDR_BITS (wraps from 2^ADDR_BITS-1 to 0); words_loaded increments; remaining decrements.
  - The strobe that brings remaining to 0 moves the FSM to DONE (or CHECK in the checksum build).
  - Back-to-back strobes on consecutive cycles are fully supported, with no stall and no dropped words.
- DONE:
  - Entered with a good load: cpu_reset=0 and load_done=1 on the cycle after the last write cycle.
  - A strobe with bit31=1 restarts a load in the same cycle: cpu_reset=1, load_done=0, load_err=0, header latched, next state LOAD (or DONE if N=0).
  - Strobes with bit31=0 are ignored.
- Error state (load_err=1): cpu_reset stays 1 and load_done=0 until a new header arrives.
- Gaps between strobes of any length are allowed. There is no timeout.
- reset_n asserted mid-load aborts the load immediately: all outputs return to reset values and BRAM contents are left as already written.
- Outside LOAD, mem_we is 0 and mem_addr/mem_wdata hold their last values.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After N data words, LOAD moves to CHECK and waits for one more strobe carrying the expected 32-bit XOR of all N data words.
  - Match: go to DONE with load_done=1 and cpu_reset=0.
  - Mismatch: go to DONE with load_err=1 and cpu_reset=1.
  - N=0: the expected checksum is 0, and a checksum word is still required.
  - The checksum word is never written to BRAM.
  - The running XOR is cleared when a header is latched.
- Not defined: the CHECK state and the XOR register are absent and load_err is tied to 0.

Decomposition:
- Shared package riscv_loader_pkg:
  - State encoding typedef.
  - Header field constants: HDR_MARK_BIT=31, HDR_CNT_MSB=30, HDR_CNT_LSB=16, HDR_ADDR_MSB=15.
- One natural sub-module, loader_addr_gen: address pointer with modulo wrap, plus the remaining/words_loaded counters. The FSM stays in the top module.

Test Plan:
- Single load: header 0x8004_0010 then words A,B,C,D on consecutive cycles → writes to addr 0x010..0x013 one cycle after each strobe; cpu_reset falls and load_done=1; words_loaded=4.
- Wrap-around (ADDR_BITS=10): header count=3, addr=0x3FE → writes at 0x3FE, 0x3FF, 0x000.
- Zero count and non-header: header 0x8000_0005 → DONE next cycle with no mem_we. Word 0x1234_5678 in IDLE → ignored, state unchanged.
- Reload and mid-load reset:
  - Header in DONE → cpu_reset=1 the next cycle and a new load completes.
  - reset_n pulsed low after 2 of 4 words → outputs reset; a later header-plus-4-words load succeeds.
- Checksum (LOADER_CHECKSUM_EN): data 0x1, 0x2, 0x4 then checksum 0x7 → load_done=1. Checksum 0x6 → load_err=1, cpu_reset stays 1, and only 3 BRAM writes occur.
- Gapped strobes: random 0–20 idle cycles between data strobes → identical BRAM contents and completion, with no extra or missing writes.
